// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO issue block: EX opcodes, unit opcode bits,
// sequencer states and the divide arming length.
package md_pkg;

   // EX-stage HI/LO opcode encoding
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MFHI  = 3'd6,
      OP_MFLO  = 3'd7
   } ex_op_e;

   // One-hot unit opcode width and bit positions
   localparam int MD_OP_W       = 6;
   localparam int MD_BIT_MULT   = 0;
   localparam int MD_BIT_MULTU  = 1;
   localparam int MD_BIT_DIV    = 2;
   localparam int MD_BIT_DIVU   = 3;
   localparam int MD_BIT_MTHI   = 4;
   localparam int MD_BIT_MTLO   = 5;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_MT  = 2'd1,
      ST_DIV_ARM  = 2'd2,
      ST_DIV_WAIT = 2'd3
   } md_state_e;

   // Cycles spent in DIV_ARM before md_accessible is trusted
   localparam int DIV_ARM_LEN = 2;
   localparam int DIV_CNT_W   = $clog2(DIV_ARM_LEN + 1);

   // Ops that are sent to the unit (everything except the HI/LO reads)
   function automatic logic is_unit_op(input ex_op_e op);
      return (op != OP_MFHI) && (op != OP_MFLO);
   endfunction

   // Ops that take the long divide path
   function automatic logic is_div_op(input ex_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Map an EX opcode onto the unit's one-hot opcode
   function automatic logic [MD_OP_W-1:0] op_onehot(input ex_op_e op);
      logic [MD_OP_W-1:0] oh;
      oh = '0;
      case (op)
         OP_MULT:  oh[MD_BIT_MULT]  = 1'b1;
         OP_MULTU: oh[MD_BIT_MULTU] = 1'b1;
         OP_DIV:   oh[MD_BIT_DIV]   = 1'b1;
         OP_DIVU:  oh[MD_BIT_DIVU]  = 1'b1;
         OP_MTHI:  oh[MD_BIT_MTHI]  = 1'b1;
         OP_MTLO:  oh[MD_BIT_MTLO]  = 1'b1;
         default:  oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/muldiv_issue.sv
// muldiv_issue: hands HI/LO-class instructions from EX to the multiply/divide
// unit, serves MFHI/MFLO reads and stalls EX while the unit is busy.
module muldiv_issue
   import md_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               ex_valid,
   input  logic [2:0]         ex_op,
   input  logic               ex_md,
   input  logic [31:0]        ex_rs,
   input  logic [31:0]        ex_rt,
   input  logic               ex_flush,
   output logic [MD_OP_W-1:0] md_op,
   output logic [31:0]        md_in0,
   output logic [31:0]        md_in1,
   output logic               md_read_hi,
   input  logic [31:0]        md_res,
   input  logic               md_accessible,
   output logic               ex_stall,
   output logic [31:0]        ex_result,
   output logic               ex_result_valid
);

   md_state_e            state_q;
   logic [DIV_CNT_W-1:0] cnt_q;
   ex_op_e               op;
   logic                 md_req;
   logic                 idle;
   logic                 issue;
   logic                 mf_read;

   // A live HI/LO request; reset and flush both silence it
   assign op      = ex_op_e'(ex_op);
   assign md_req  = ex_valid & ex_md & ~ex_flush & ~rst;
   assign idle    = (state_q == ST_IDLE);
   assign issue   = md_req & idle & is_unit_op(op);
   assign mf_read = md_req & idle & ~is_unit_op(op);

   // Issue is never stalled: the pipeline moves on while the unit works
   assign ex_stall = md_req & ~idle;

   // Unit request and HI/LO read path; all outputs are zero outside an issue or read
   always_comb begin
      md_op           = '0;
      md_in0          = '0;
      md_in1          = '0;
      md_read_hi      = 1'b0;
      ex_result       = '0;
      ex_result_valid = 1'b0;
      if (issue) begin
         md_op = op_onehot(op);
         case (op)
            OP_MTHI: md_in0 = ex_rs;
            OP_MTLO: md_in1 = ex_rs;
            default: begin
               md_in0 = ex_rs;
               md_in1 = ex_rt;
            end
         endcase
      end
      if (mf_read) begin
         md_read_hi      = (op == OP_MFHI);
         ex_result       = md_res;
         ex_result_valid = 1'b1;
      end
   end

   // Sequencer: one settle cycle after MULT/MT, arm-then-wait after DIV.
   // A flush never aborts an operation already handed to the unit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (issue) begin
                  state_q <= is_div_op(op) ? ST_DIV_ARM : ST_WAIT_MT;
                  cnt_q   <= '0;
               end
            end
            ST_WAIT_MT: begin
               state_q <= ST_IDLE;
            end
            ST_DIV_ARM: begin
               // md_accessible may still show the previous result here, so ignore it
               if (cnt_q == DIV_CNT_W'(DIV_ARM_LEN - 1)) begin
                  state_q <= ST_DIV_WAIT;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + DIV_CNT_W'(1);
               end
            end
            ST_DIV_WAIT: begin
               if (md_accessible) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_issue.sv
// Testbench for muldiv_issue: a behavioural multiply/divide unit answers the
// DUT's requests, and a separate instruction-level reference predicts results.
module tb_muldiv_issue;

   localparam logic [2:0] T_MULT = 3'd0, T_MULTU = 3'd1, T_DIV = 3'd2, T_DIVU = 3'd3;
   localparam logic [2:0] T_MTHI = 3'd4, T_MTLO = 3'd5, T_MFHI = 3'd6, T_MFLO = 3'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0, ex_md = 1'b0, ex_flush = 1'b0;
   logic [2:0]  ex_op = 3'd0;
   logic [31:0] ex_rs = 32'd0, ex_rt = 32'd0;
   logic [5:0]  md_op;
   logic [31:0] md_in0, md_in1, md_res, ex_result;
   logic        md_read_hi, md_accessible, ex_stall, ex_result_valid;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   muldiv_issue dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_md(ex_md),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_flush(ex_flush), .md_op(md_op),
      .md_in0(md_in0), .md_in1(md_in1), .md_read_hi(md_read_hi), .md_res(md_res),
      .md_accessible(md_accessible), .ex_stall(ex_stall), .ex_result(ex_result),
      .ex_result_valid(ex_result_valid)
   );

   // {HI, LO} produced by MULT/MULTU/DIV/DIVU on operands a, b
   function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = 64'd0;
      case (op)
         3'd0: r = 64'(sa * sb);
         3'd1: r = 64'(a) * 64'(b);
         3'd2: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
         3'd3: if (b != 0) r = {a % b, a / b};
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   // ---------------- behavioural multiply/divide unit ----------------
   logic [31:0] u_hi, u_lo, u_phi, u_plo;
   logic        u_acc;
   int          u_left;
   int          lat_force = 0;
   logic [63:0] u_mul, u_mulu, u_div, u_divu;

   assign u_mul         = calc(3'd0, md_in0, md_in1);
   assign u_mulu        = calc(3'd1, md_in0, md_in1);
   assign u_div         = calc(3'd2, md_in0, md_in1);
   assign u_divu        = calc(3'd3, md_in0, md_in1);
   assign md_res        = md_read_hi ? u_hi : u_lo;
   assign md_accessible = u_acc;

   always @(posedge clk) begin
      if (rst) begin
         u_hi <= 32'd0; u_lo <= 32'd0; u_phi <= 32'd0; u_plo <= 32'd0;
         u_acc <= 1'b1; u_left <= 0;
      end else begin
         case (md_op)
            6'b000001: begin u_hi <= u_mul[63:32];  u_lo <= u_mul[31:0];  end
            6'b000010: begin u_hi <= u_mulu[63:32]; u_lo <= u_mulu[31:0]; end
            6'b000100: begin
               u_phi <= u_div[63:32]; u_plo <= u_div[31:0]; u_acc <= 1'b0;
               u_left <= (lat_force != 0) ? lat_force : int'($urandom_range(5, 1));
            end
            6'b001000: begin
               u_phi <= u_divu[63:32]; u_plo <= u_divu[31:0]; u_acc <= 1'b0;
               u_left <= (lat_force != 0) ? lat_force : int'($urandom_range(5, 1));
            end
            6'b010000: u_hi <= md_in0;
            6'b100000: u_lo <= md_in1;
            default: begin
               if (u_left != 0) begin
                  u_left <= u_left - 1;
                  if (u_left == 1) begin
                     u_acc <= 1'b1; u_hi <= u_phi; u_lo <= u_plo;
                  end
               end
            end
         endcase
      end
   end

   // ---------------- instruction-level reference ----------------
   // busy_cycles: cycles the block is certainly busy; div_pending: a divide
   // still waiting on the unit's completion signal.
   logic [31:0] r_hi = 32'd0, r_lo = 32'd0;
   int          busy_cycles = 0;
   logic        div_pending = 1'b0;
   logic        acc_now;
   logic        e_issue, e_read, e_stall;
   logic [5:0]  e_mdop;
   logic [31:0] e_in0, e_in1, e_res;

   // Drive one EX cycle after the falling edge and work out what should happen
   task automatic drive(input logic r, input logic v, input logic md, input logic [2:0] op,
                        input logic [31:0] rs, input logic [31:0] rt, input logic fl);
      logic idle, req;
      @(negedge clk);
      rst = r; ex_valid = v; ex_md = md; ex_op = op; ex_rs = rs; ex_rt = rt; ex_flush = fl;
      #1;
      idle    = (busy_cycles == 0) && !div_pending;
      req     = v && md && !fl && !r;
      e_issue = req && idle && (op <= 3'd5);
      e_read  = req && idle && (op >= 3'd6);
      e_stall = req && !idle;
      e_mdop  = e_issue ? (6'b000001 << op) : 6'b0;
      e_in0   = (e_issue && op != T_MTLO) ? rs : 32'd0;
      e_in1   = !e_issue ? 32'd0 : (op == T_MTHI) ? 32'd0 : (op == T_MTLO) ? rs : rt;
      e_res   = e_read ? ((op == T_MFHI) ? r_hi : r_lo) : 32'd0;
      acc_now = md_accessible;
   endtask

   // Commit the cycle at the rising edge into the reference
   task automatic advance();
      logic [63:0] p;
      @(posedge clk);
      if (rst) begin
         busy_cycles = 0; div_pending = 1'b0; r_hi = 32'd0; r_lo = 32'd0;
      end else if (e_issue) begin
         if (ex_op <= 3'd3) begin
            p = calc(ex_op, ex_rs, ex_rt);
            r_hi = p[63:32]; r_lo = p[31:0];
         end else if (ex_op == T_MTHI) r_hi = ex_rs;
         else r_lo = ex_rs;
         div_pending = (ex_op == T_DIV) || (ex_op == T_DIVU);
         busy_cycles = div_pending ? 2 : 1;
      end else if (busy_cycles != 0) begin
         busy_cycles = busy_cycles - 1;
      end else if (div_pending && acc_now) begin
         div_pending = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b1, T_MULT, $urandom, $urandom, 1'b0);
         n_cmp++; if (md_op !== 6'b0) begin n_bad++; $display("FAIL reset_md_op: got %b want 000000", md_op); end
         n_cmp++; if (ex_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", ex_stall); end
         n_cmp++; if (ex_result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rv: got %b want 0", ex_result_valid); end
         n_cmp++; if ({md_in0, md_in1} !== 64'd0) begin n_bad++; $display("FAIL reset_in: got %h/%h want 0/0", md_in0, md_in1); end
         n_cmp++; if (ex_result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", ex_result); end
         advance();
      end
      $display("txn reset: outputs held at zero");
   endtask

   task automatic test_mult_read();
      // MULT 7,-3 then an unrelated instruction, then MFLO
      drive(1'b0, 1'b1, 1'b1, T_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
      n_cmp++; if (md_op !== 6'b000001) begin n_bad++; $display("FAIL mult_md_op: got %b want 000001", md_op); end
      n_cmp++; if (md_in0 !== 32'd7 || md_in1 !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL mult_in: got %h/%h want 00000007/fffffffd", md_in0, md_in1); end
      n_cmp++; if (ex_stall !== 1'b0) begin n_bad++; $display("FAIL mult_issue_stall: got %b want 0", ex_stall); end
      advance();
      drive(1'b0, 1'b1, 1'b0, T_MFLO, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (md_op !== 6'b0 || ex_stall !== 1'b0) begin n_bad++; $display("FAIL mult_t1_nonmd: got op=%b stall=%b want 000000/0", md_op, ex_stall); end
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MFLO, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_result !== 32'hFFFF_FFEB || ex_result_valid !== 1'b1) begin n_bad++; $display("FAIL mult_mflo: got %h rv=%b want ffffffeb rv=1", ex_result, ex_result_valid); end
      n_cmp++; if (ex_stall !== 1'b0 || md_read_hi !== 1'b0) begin n_bad++; $display("FAIL mult_mflo_ctl: got stall=%b hi=%b want 0/0", ex_stall, md_read_hi); end
      advance();
      $display("txn MULT 7,-3 -> MFLO %h", 32'hFFFF_FFEB);
      // MULT again with MFHI right behind it: one stall cycle in WAIT_MT
      drive(1'b0, 1'b1, 1'b1, T_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MFHI, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_stall !== 1'b1 || ex_result_valid !== 1'b0) begin n_bad++; $display("FAIL waitmt_stall: got stall=%b rv=%b want 1/0", ex_stall, ex_result_valid); end
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MFHI, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_stall !== 1'b0 || ex_result !== 32'hFFFF_FFFF || md_read_hi !== 1'b1) begin n_bad++; $display("FAIL waitmt_mfhi: got stall=%b res=%h hi=%b want 0/ffffffff/1", ex_stall, ex_result, md_read_hi); end
      advance();
      $display("txn MULT 7,-3 -> MFHI %h after one stall", 32'hFFFF_FFFF);
   endtask

   task automatic test_div_stall();
      int   stalls;
      logic done;
      lat_force = 0;
      drive(1'b0, 1'b1, 1'b1, T_DIV, 32'd100, 32'd7, 1'b0);
      n_cmp++; if (md_op !== 6'b000100 || ex_stall !== 1'b0) begin n_bad++; $display("FAIL div_issue: got op=%b stall=%b want 000100/0", md_op, ex_stall); end
      advance();
      stalls = 0; done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         drive(1'b0, 1'b1, 1'b1, T_MFHI, 32'd0, 32'd0, 1'b0);
         n_cmp++; if (ex_stall !== e_stall) begin n_bad++; $display("FAIL div_stall_cyc%0d: got %b want %b", i, ex_stall, e_stall); end
         if (ex_stall === 1'b0) begin
            done = 1'b1;
            n_cmp++; if (ex_result !== 32'd2 || ex_result_valid !== 1'b1) begin n_bad++; $display("FAIL div_mfhi: got %h rv=%b want 00000002 rv=1", ex_result, ex_result_valid); end
         end else begin
            stalls++;
         end
         advance();
      end
      n_cmp++; if (!done) begin n_bad++; $display("FAIL div_timeout: stall never released within 30 cycles, want release"); end
      n_cmp++; if (stalls < 3) begin n_bad++; $display("FAIL div_min_stall: got %0d stall cycles want at least 3", stalls); end
      drive(1'b0, 1'b0, 1'b1, T_MFHI, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_result_valid !== 1'b0) begin n_bad++; $display("FAIL div_rv_one_cycle: got %b want 0", ex_result_valid); end
      advance();
      $display("txn DIV 100,7 -> MFHI 2 after %0d stall cycles", stalls);
   endtask

   task automatic test_mthi_back_to_back();
      drive(1'b0, 1'b1, 1'b1, T_MTHI, 32'hDEAD_BEEF, 32'h5555_5555, 1'b0);
      n_cmp++; if (md_op !== 6'b010000 || md_in0 !== 32'hDEAD_BEEF || md_in1 !== 32'd0) begin n_bad++; $display("FAIL mthi_issue: got %b %h/%h want 010000 deadbeef/0", md_op, md_in0, md_in1); end
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MFHI, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_stall !== 1'b1) begin n_bad++; $display("FAIL mthi_stall: got %b want 1", ex_stall); end
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MFHI, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_stall !== 1'b0 || ex_result !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL mthi_read: got stall=%b res=%h want 0/deadbeef", ex_stall, ex_result); end
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MTLO, 32'h1234_5678, 32'hAAAA_AAAA, 1'b0);
      n_cmp++; if (md_op !== 6'b100000 || md_in0 !== 32'd0 || md_in1 !== 32'h1234_5678) begin n_bad++; $display("FAIL mtlo_issue: got %b %h/%h want 100000 0/12345678", md_op, md_in0, md_in1); end
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MFLO, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_stall !== 1'b1) begin n_bad++; $display("FAIL mtlo_stall: got %b want 1", ex_stall); end
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MFLO, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_result !== 32'h1234_5678 || ex_result_valid !== 1'b1) begin n_bad++; $display("FAIL mtlo_read: got %h rv=%b want 12345678 rv=1", ex_result, ex_result_valid); end
      advance();
      $display("txn MTHI/MFHI deadbeef, MTLO/MFLO 12345678");
   endtask

   task automatic test_flush();
      drive(1'b0, 1'b1, 1'b1, T_DIV, 32'd50, 32'd3, 1'b1);
      n_cmp++; if (md_op !== 6'b0 || ex_stall !== 1'b0) begin n_bad++; $display("FAIL flush_div: got op=%b stall=%b want 000000/0", md_op, ex_stall); end
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MFLO, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_stall !== 1'b0 || ex_result !== 32'h1234_5678) begin n_bad++; $display("FAIL flush_idle_read: got stall=%b res=%h want 0/12345678", ex_stall, ex_result); end
      advance();
      // A flushed read in a busy cycle neither stalls nor reads
      drive(1'b0, 1'b1, 1'b1, T_MULTU, 32'd3, 32'd5, 1'b0);
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MFLO, 32'd0, 32'd0, 1'b1);
      n_cmp++; if (ex_stall !== 1'b0 || ex_result_valid !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got stall=%b rv=%b want 0/0", ex_stall, ex_result_valid); end
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MFLO, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_result !== 32'd15) begin n_bad++; $display("FAIL flush_multu_read: got %h want 0000000f", ex_result); end
      advance();
      $display("txn flushed DIV dropped, MULTU 3,5 -> 15");
   endtask

   task automatic test_reset_in_div();
      lat_force = 20;
      drive(1'b0, 1'b1, 1'b1, T_DIVU, 32'd1000, 32'd9, 1'b0);
      advance();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, T_MULT, 32'd0, 32'd0, 1'b0);
         advance();
      end
      drive(1'b0, 1'b1, 1'b1, T_MFHI, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_stall !== 1'b1) begin n_bad++; $display("FAIL divwait_stall: got %b want 1", ex_stall); end
      advance();
      drive(1'b1, 1'b1, 1'b1, T_MFHI, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_stall !== 1'b0 || md_op !== 6'b0 || ex_result_valid !== 1'b0) begin n_bad++; $display("FAIL rst_divwait_out: got stall=%b op=%b rv=%b want 0/000000/0", ex_stall, md_op, ex_result_valid); end
      advance();
      lat_force = 0;
      drive(1'b0, 1'b1, 1'b1, T_MFHI, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_stall !== 1'b0 || ex_result_valid !== 1'b1 || ex_result !== 32'd0) begin n_bad++; $display("FAIL rst_idle_read: got stall=%b rv=%b res=%h want 0/1/0", ex_stall, ex_result_valid, ex_result); end
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      n_cmp++; if (md_op !== 6'b000010 || ex_stall !== 1'b0) begin n_bad++; $display("FAIL rst_multu_issue: got op=%b stall=%b want 000010/0", md_op, ex_stall); end
      advance();
      drive(1'b0, 1'b0, 1'b0, T_MULT, 32'd0, 32'd0, 1'b0);
      advance();
      drive(1'b0, 1'b1, 1'b1, T_MFHI, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (ex_result !== 32'd1) begin n_bad++; $display("FAIL rst_multu_hi: got %h want 00000001", ex_result); end
      advance();
      $display("txn reset in DIV_WAIT, then MULTU ffffffff,2 -> HI 1");
   endtask

   task automatic test_random();
      logic        v, md, fl;
      logic [2:0]  op;
      logic [31:0] rs, rt;
      for (int i = 0; i < 200; i++) begin
         v  = ($urandom % 4) != 0;
         md = ($urandom % 3) != 0;
         fl = ($urandom % 8) == 0;
         op = 3'($urandom % 8);
         rs = $urandom;
         rt = ($urandom % 4 == 0) ? 32'($urandom % 16) : $urandom;
         if ((op == T_DIV || op == T_DIVU) && rt == 32'd0) rt = 32'd1;
         drive(1'b0, v, md, op, rs, rt, fl);
         n_cmp++; if (md_op !== e_mdop) begin n_bad++; $display("FAIL rnd%0d_md_op: got %b want %b", i, md_op, e_mdop); end
         n_cmp++; if (ex_stall !== e_stall) begin n_bad++; $display("FAIL rnd%0d_stall: got %b want %b", i, ex_stall, e_stall); end
         n_cmp++; if (md_in0 !== e_in0 || md_in1 !== e_in1) begin n_bad++; $display("FAIL rnd%0d_in: got %h/%h want %h/%h", i, md_in0, md_in1, e_in0, e_in1); end
         n_cmp++; if (ex_result_valid !== e_read || ex_result !== e_res) begin n_bad++; $display("FAIL rnd%0d_result: got rv=%b %h want rv=%b %h", i, ex_result_valid, ex_result, e_read, e_res); end
         if (e_read) begin
            n_cmp++; if (md_read_hi !== (op == T_MFHI)) begin n_bad++; $display("FAIL rnd%0d_read_hi: got %b want %b", i, md_read_hi, op == T_MFHI); end
         end
         $display("txn rnd%0d: v=%b md=%b fl=%b op=%0d rs=%h rt=%h issue=%b read=%b stall=%b res=%h",
                  i, v, md, fl, op, rs, rt, e_issue, e_read, ex_stall, ex_result);
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_mult_read();
      test_div_stall();
      test_mthi_back_to_back();
      test_flush();
      test_reset_in_div();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard stop in case a scenario wedges
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/muldiv_issue.md
MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port ex_valid, input, 1 bit: the EX stage holds a valid instruction.
REQ-004 SHALL have port ex_op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-005 SHALL have port ex_md, input, 1 bit: the EX instruction is a HI/LO-class instruction.
REQ-006 SHALL have port ex_rs, input, 32 bits: first operand (rs value).
REQ-007 SHALL have port ex_rt, input, 32 bits: second operand (rt value).
REQ-008 SHALL have port ex_flush, input, 1 bit: the EX instruction is killed this cycle.
REQ-009 SHALL have port md_op, output, 6 bits: one-hot unit opcode {5:MTLO, 4:MTHI, 3:DIVU, 2:DIV, 1:MULTU, 0:MULT}.
REQ-010 SHALL have port md_in0, output, 32 bits: operand 0 to the unit.
REQ-011 SHALL have port md_in1, output, 32 bits: operand 1 to the unit.
REQ-012 SHALL have port md_read_hi, output, 1 bit: 1 selects HI, 0 selects LO on md_res.
REQ-013 SHALL have port md_res, input, 32 bits: HI/LO read data from the unit.
REQ-014 SHALL have port md_accessible, input, 1 bit: the unit's HI/LO contents are valid.
REQ-015 SHALL have port ex_stall, output, 1 bit: hold the EX stage this cycle.
REQ-016 SHALL have port ex_result, output, 32 bits: MFHI/MFLO result.
REQ-017 SHALL have port ex_result_valid, output, 1 bit: ex_result is valid this cycle.

Function
REQ-018 SHALL contain a FSM with states IDLE, WAIT_MT, DIV_ARM, DIV_WAIT.
REQ-019 An issue SHALL occur when ex_valid & ex_md & !ex_flush & op<=5 & state==IDLE.
REQ-020 An issue SHALL drive md_op with the one-hot bit for the op for exactly one cycle; md_op SHALL be 0 in every other cycle.
REQ-021 On issue, md_in0/md_in1 SHALL equal ex_rs/ex_rt for MULT/DIV ops, {ex_rs, 32'b0} for MTHI, and {32'b0, ex_rs} for MTLO.
REQ-022 After issuing MULT, MULTU, MTHI or MTLO, the FSM SHALL go IDLE->WAIT_MT; WAIT_MT SHALL return to IDLE after 1 cycle.
REQ-023 After issuing DIV or DIVU, the FSM SHALL go IDLE->DIV_ARM (2-cycle counter, md_accessible ignored) ->DIV_WAIT, and DIV_WAIT->IDLE on the first cycle md_accessible==1.
REQ-024 MFHI/MFLO in IDLE SHALL drive md_read_hi=(op==6) and ex_result=md_res combinationally, with ex_result_valid=1 and ex_stall=0.
REQ-025 ex_stall SHALL be 1 when ex_valid & ex_md & !ex_flush & state!=IDLE; this covers any HI/LO op, reads included.
REQ-026 ex_stall SHALL be 0 on the issue cycle itself; the pipeline advances immediately.
REQ-027 ex_flush SHALL suppress an issue/read in the same cycle; a flush in a non-IDLE state SHALL NOT abort the in-flight operation, and the FSM SHALL continue to IDLE.
REQ-028 Non-md or invalid EX instructions SHALL never stall and never drive md_op.
REQ-029 DIV_WAIT SHALL have no timeout; the unit guarantees completion.

Reset
REQ-030 While rst=1 the FSM SHALL be IDLE, the counter 0, md_op=0, ex_stall=0, ex_result_valid=0, and md_in0/md_in1/ex_result=0.
REQ-031 A reset during DIV_WAIT SHALL return to IDLE next cycle; the unit is reset on the same reset.

Structure
REQ-032 The ex_op encodings, one-hot md_op bit positions, state encodings and DIV_ARM length (2) SHALL reside in shared package md_pkg.
REQ-033 The block SHALL be a single module with no sub-module; the FSM and counter SHALL be inline.

Verification
REQ-034 MULT 7,-3 issued at T -> md_op=000001 at T only, WAIT_MT at T+1; MFLO at T+2 returns 0xFFFFFFEB with no stall.
REQ-035 DIV 100,7 at T, then MFHI at T+1 -> ex_stall=1 until md_accessible rises; result then equals 2 with result_valid for 1 cycle.
REQ-036 MTHI 0xDEADBEEF then MFHI back-to-back -> one stall cycle, then 0xDEADBEEF.
REQ-037 DIV with ex_flush=1 -> md_op stays 0, state stays IDLE.
REQ-038 rst asserted in DIV_WAIT -> next cycle IDLE, all outputs 0; a following MULTU issues normally.
